// File: rtl/gray_counter.sv
// Up/down Gray-code counter with Gray-value load, wrap or saturate at the bounds,
// and a one-cycle terminal-count pulse. Gray and binary views are registered together.
module gray_counter #(
    parameter int VEC_W    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [VEC_W-1:0] load_gray_i,
    output logic [VEC_W-1:0] gray_o,
    output logic [VEC_W-1:0] bin_o,
    output logic             tc_o
);

    localparam logic [VEC_W-1:0] MAX_VAL  = {VEC_W{1'b1}};
    localparam logic [VEC_W-1:0] ZERO_VAL = {VEC_W{1'b0}};
    localparam logic [VEC_W-1:0] ONE_VAL  = {{(VEC_W-1){1'b0}}, 1'b1};

    function automatic logic [VEC_W-1:0] bin2gray(input logic [VEC_W-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // MSB passes through; each lower bit folds in the binary bit above it.
    function automatic logic [VEC_W-1:0] gray2bin(input logic [VEC_W-1:0] g);
        logic [VEC_W-1:0] b;
        b[VEC_W-1] = g[VEC_W-1];
        for (int i = VEC_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [VEC_W-1:0] bin_r;
    logic [VEC_W-1:0] gray_r;
    logic             tc_r;
    logic [VEC_W-1:0] next_bin_s;
    logic [VEC_W-1:0] next_gray_s;
    logic             next_tc_s;

    // Next-state selection: load beats count, count beats hold.
    always_comb begin
        next_bin_s  = bin_r;
        next_gray_s = gray_r;
        next_tc_s   = 1'b0;
        if (load_i) begin
            next_bin_s  = gray2bin(load_gray_i);
            next_gray_s = load_gray_i;
        end else if (en_i) begin
            if (up_i) begin
                if (bin_r == MAX_VAL) begin
                    next_tc_s  = 1'b1;
                    next_bin_s = SATURATE ? MAX_VAL : ZERO_VAL;
                end else begin
                    next_bin_s = bin_r + ONE_VAL;
                end
            end else begin
                if (bin_r == ZERO_VAL) begin
                    next_tc_s  = 1'b1;
                    next_bin_s = SATURATE ? ZERO_VAL : MAX_VAL;
                end else begin
                    next_bin_s = bin_r - ONE_VAL;
                end
            end
            next_gray_s = bin2gray(next_bin_s);
        end else begin
            next_bin_s  = bin_r;
            next_gray_s = gray_r;
        end
    end

    // Binary, Gray and terminal-count registers share one edge so the views never skew.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_r  <= ZERO_VAL;
            gray_r <= ZERO_VAL;
            tc_r   <= 1'b0;
        end else begin
            bin_r  <= next_bin_s;
            gray_r <= next_gray_s;
            tc_r   <= next_tc_s;
        end
    end

    assign bin_o  = bin_r;
    assign gray_o = gray_r;
    assign tc_o   = tc_r;

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
Parametrised Gray-code counter. It is the sequential successor to the combinational binary-to-Gray converter and is built for pointer and position tracking across the design. It keeps a binary count and presents registered Gray and binary views of it. It adds up/down counting, load of a Gray value (with internal Gray-to-binary conversion), wrap or saturate mode, and a terminal-count pulse.

Parameters:
VEC_W, 4, counter width in bits (legal range 2..32)
SATURATE, 0, 0 = wrap at the bounds; 1 = hold at the bounds

Ports:
clk  input  1  single clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
en_i  input  1  count enable; one step per cycle while high
up_i  input  1  direction: 1 = increment, 0 = decrement (sampled only when en_i=1)
load_i  input  1  load request
load_gray_i  input  VEC_W  Gray-coded value to load
gray_o  output  VEC_W  registered Gray code of the current count
bin_o  output  VEC_W  registered binary count
tc_o  output  1  registered terminal-count pulse

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset; no asynchronous reset anywhere.
- Reset values: bin_o=0, gray_o=0, tc_o=0. Reset has top priority and also applies mid-count or mid-load.
- Priority each cycle: reset > load_i > en_i > hold.
- Load:
  - bin_o <= gray2bin(load_gray_i), where b[W-1]=g[W-1] and b[i]=b[i+1]^g[i].
  - gray_o <= load_gray_i exactly.
  - tc_o <= 0.
  - Visible the cycle after load_i is sampled. en_i is ignored in that cycle.
- Count, en_i=1 and up_i=1:
  - If bin_o != max (2^VEC_W-1): bin_o+1.
  - If bin_o == max and SATURATE=0: wrap to 0, tc_o <= 1.
  - If bin_o == max and SATURATE=1: hold at max, tc_o <= 1.
- Count, en_i=1 and up_i=0:
  - If bin_o != 0: bin_o-1.
  - If bin_o == 0 and SATURATE=0: wrap to max, tc_o <= 1.
  - If bin_o == 0 and SATURATE=1: hold at 0, tc_o <= 1.
- tc_o timing: a one-cycle pulse in the cycle after the boundary step. It is 0 in every other cycle, including hold, load and reset. In saturate mode it re-pulses on every enabled cycle spent pinned at the bound.
- Gray/binary consistency:
  - gray_o is always (bin_o >> 1) ^ bin_o. It is computed from the next binary value and registered in the same edge as bin_o, so it is glitch-free and has zero cycles of skew relative to bin_o.
  - Latency from an en_i/load_i sample to the new output is 1 cycle.
- Single-bit property: any enabled step that changes the count, including a wrap in either direction, changes exactly one bit of gray_o. A saturated hold changes none.
- Direction change takes effect on the very next enabled cycle; no turnaround penalty.
- en_i=0 and load_i=0: all outputs hold; tc_o=0.
- Arithmetic is modulo 2^VEC_W in wrap mode. There is no intermediate wider than VEC_W except the comparison constants.

Test Plan:
1. Reset, then VEC_W=4, SATURATE=0, en_i=1, up_i=1 for 16 cycles.
   - gray_o must be 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8 (hex) while bin_o runs 0..F.
   - Next cycle: gray_o=0, bin_o=0, tc_o=1 for exactly one cycle.
   - Every step must change exactly one gray_o bit.
2. From reset, en_i=1, up_i=0 for one cycle.
   - bin_o=F, gray_o=8, tc_o=1.
   - Continuing down gives bin_o=E, gray_o=9, tc_o=0.
3. load_i=1, load_gray_i=4'hC, en_i=1 in the same cycle.
   - Next cycle: gray_o=C, bin_o=8, tc_o=0 (load wins over en_i).
   - Then one up step gives bin_o=9, gray_o=D.
4. SATURATE=1:
   - Load gray 8 (bin F), then en_i=1, up_i=1 for 3 cycles: bin_o stays F, gray_o stays 8, tc_o=1 on each of the 3 cycles.
   - Switch up_i=0: bin_o=E, tc_o=0.
5. Reset mid-operation: count to bin_o=5, then assert reset together with load_i=1 and en_i=1.
   - Next cycle: bin_o=0, gray_o=0, tc_o=0.
   - Counting resumes from 0 after reset is released.
6. VEC_W=8, random mix of en_i/up_i/load_i over 10k cycles.
   - Scoreboard: gray_o==(bin_o>>1)^bin_o every cycle.
   - Each non-load change of gray_o has Hamming distance 1.
   - tc_o matches the reference model bit-exactly.
